renode_axi_lite_manager: RTL



---
 rtl/renode_pkg.sv | 42 ++++
 rtl/renode_bus_timeout.sv | 28 ++
 rtl/renode_axi_lite_manager.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/renode_pkg.sv
// rtl/renode_pkg.sv - shared types for the Renode co-simulation bus path
package renode_pkg;

    localparam int ADDRESS_WIDTH = 20;
    localparam int DATA_WIDTH    = 32;

    typedef logic [ADDRESS_WIDTH-1:0] address_t;
    typedef logic [DATA_WIDTH-1:0]    data_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RESPOND
    } manager_state_e;

    typedef struct packed {
        logic     write;
        address_t address;
        data_t    data;
    } bus_request_t;

    typedef struct packed {
        data_t data;
        logic  error;
        logic  timeout;
    } bus_response_t;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/renode_bus_timeout.sv
// rtl/renode_bus_timeout.sv - per-transaction cycle counter with expiry flag
module renode_bus_timeout #(
    parameter int Timeout = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] LAST_COUNT = 16'(Timeout - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/renode_axi_lite_manager.sv
// rtl/renode_axi_lite_manager.sv - single-outstanding AXI4-Lite manager with cycle-exact timeout
module renode_axi_lite_manager
    import renode_pkg::*;
#(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32,
    parameter int Timeout      = 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [AddressWidth-1:0]   req_addr,
    input  logic [DataWidth-1:0]      req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DataWidth-1:0]      rsp_rdata,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [AddressWidth-1:0]   awaddr,
    output logic [2:0]                awprot,
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DataWidth-1:0]      wdata,
    output logic [DataWidth/8-1:0]    wstrb,
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [AddressWidth-1:0]   araddr,
    output logic [2:0]                arprot,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DataWidth-1:0]      rdata,
    input  logic [1:0]                rresp
);

    manager_state_e            r_state;
    manager_state_e            w_next_state;
    logic [AddressWidth-1:0]   r_addr;
    logic [DataWidth-1:0]      r_wdata;
    logic [DataWidth-1:0]      r_rsp_rdata;
    logic                      r_awvalid;
    logic                      r_wvalid;
    logic                      r_arvalid;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic                      r_rsp_error;
    logic                      r_rsp_timeout;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_busy;
    logic w_expired;
    logic w_timeout_fire;
    logic w_wr_req_done;
    logic w_r_err;

    assign w_accept      = req_valid && req_ready;
    assign w_aw_hs       = r_awvalid && awready;
    assign w_w_hs        = r_wvalid && wready;
    assign w_ar_hs       = r_arvalid && arready;
    assign w_b_hs        = bvalid && bready;
    assign w_r_hs        = rvalid && rready;
    assign w_wr_req_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_r_err       = resp_is_error(rresp);
    assign w_busy        = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                           (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);

    renode_bus_timeout #(
        .Timeout (Timeout)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_enable  (w_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A handshake completing in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_next_state   = r_state;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = req_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (w_wr_req_done) begin
                    w_next_state = ST_WR_RESP;
                end else if (w_expired) begin
                    w_next_state   = ST_RESPOND;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_next_state = ST_RESPOND;
                end else if (w_expired) begin
                    w_next_state   = ST_RESPOND;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (w_ar_hs) begin
                    w_next_state = ST_RD_DATA;
                end else if (w_expired) begin
                    w_next_state   = ST_RESPOND;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    w_next_state = ST_RESPOND;
                end else if (w_expired) begin
                    w_next_state   = ST_RESPOND;
                    w_timeout_fire = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (r_state == ST_IDLE);
        bready    = (r_state == ST_WR_RESP);
        rready    = (r_state == ST_RD_DATA);
        rsp_valid = (r_state == ST_RESPOND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_wdata       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_awvalid <= req_write;
                r_wvalid  <= req_write;
                r_arvalid <= !req_write;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (w_timeout_fire) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_arvalid <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end
                if (w_ar_hs) begin
                    r_arvalid <= 1'b0;
                end
            end

            if (w_timeout_fire) begin
                r_rsp_rdata   <= '0;
                r_rsp_error   <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end else if (w_b_hs) begin
                r_rsp_rdata   <= '0;
                r_rsp_error   <= resp_is_error(bresp);
                r_rsp_timeout <= 1'b0;
            end else if (w_r_hs) begin
                r_rsp_rdata   <= w_r_err ? '0 : rdata;
                r_rsp_error   <= w_r_err;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign awvalid     = r_awvalid;
    assign wvalid      = r_wvalid;
    assign arvalid     = r_arvalid;
    assign awaddr      = r_addr;
    assign araddr      = r_addr;
    assign wdata       = r_wdata;
    assign wstrb       = '1;
    assign awprot      = 3'b000;
    assign arprot      = 3'b000;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;

endmodule
